// File: rtl/fetch_ctrl.sv
// fetch_ctrl: two-cycle instruction fetch sequencer with redirect, stall and accepted-instruction count.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        irWrite,
  output logic [31:0] pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);
  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state, state_n;
  logic accept;
  always_comb begin
    irWrite    = state == FETCH;
    inst_valid = state == VALID;
    accept     = inst_valid && inst_ready && !redirect_valid;
    state_n    = redirect_valid ? FETCH :
                 state == IDLE  ? FETCH :
                 state == FETCH ? VALID :
                 accept         ? FETCH : VALID;
  end
  // redirect outranks acceptance, so a same-cycle handshake never advances pc or the count
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      inst_pc     <= RESET_PC;
      fetch_count <= '0;
      fetch_err   <= 1'b0;
    end else begin
      state     <= state_n;
      fetch_err <= redirect_valid && |redirect_target[1:0];
      if (state == FETCH) inst_pc <= pc;
      if (redirect_valid) pc <= {redirect_target[31:2], 2'b00};
      else if (accept) pc <= pc + 32'd4;
      if (accept) fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed checks of fetch sequencing, stall, redirect, wrap and reset.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst, inst_ready, redirect_valid;
  logic [31:0] redirect_target;
  logic irwrite, inst_valid, fetch_err;
  logic [31:0] pc, inst_pc, fetch_count;
  logic irwrite_w, inst_valid_w, fetch_err_w;
  logic [31:0] pc_w, inst_pc_w, fetch_count_w;
  logic [31:0] mem [256];
  logic [31:0] rdata;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .irWrite(irwrite), .pc(pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .irWrite(irwrite_w), .pc(pc_w), .inst_valid(inst_valid_w),
    .inst_ready(inst_ready), .inst_pc(inst_pc_w), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .fetch_err(fetch_err_w), .fetch_count(fetch_count_w)
  );

  always @(posedge clk) if (irwrite) rdata <= mem[pc[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = i;
    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    step(); step();
    check("rst_irwrite", irwrite, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_count", fetch_count, 0);
    check("rst_err", fetch_err, 0);
    check("rst_wrap_pc", pc_w, 32'hFFFF_FFFC);
    rst = 1'b0;
    check("c0_irwrite", irwrite, 0);
    step();
    check("c1_irwrite", irwrite, 1);
    check("c1_valid", inst_valid, 0);
    check("c1_pc", pc, 0);
    check("c1_wrap_pc", pc_w, 32'hFFFF_FFFC);
    step();
    check("c2_valid", inst_valid, 1);
    check("c2_irwrite", irwrite, 0);
    check("c2_inst_pc", inst_pc, 0);
    check("c2_data", rdata, 0);
    step();
    check("c3_irwrite", irwrite, 1);
    check("c3_pc", pc, 4);
    check("c3_count", fetch_count, 1);
    check("c3_wrap_pc", pc_w, 0);
    step();
    check("c4_inst_pc", inst_pc, 4);
    check("c4_data", rdata, 1);
    step();
    check("c5_irwrite", irwrite, 1);
    check("c5_pc", pc, 8);
    step();
    check("c6_valid", inst_valid, 1);
    check("c6_inst_pc", inst_pc, 8);
    check("c6_count", fetch_count, 2);
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", inst_valid, 1);
      check("stall_irwrite", irwrite, 0);
      check("stall_inst_pc", inst_pc, 8);
      check("stall_pc", pc, 8);
      check("stall_count", fetch_count, 2);
    end
    inst_ready = 1'b1;
    step();
    check("resume_pc", pc, 12);
    check("resume_count", fetch_count, 3);
    check("resume_irwrite", irwrite, 1);
    step();
    check("resume_inst_pc", inst_pc, 12);
    check("resume_data", rdata, 3);
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_pc", pc, 32'h40);
    check("redir_irwrite", irwrite, 1);
    check("redir_valid", inst_valid, 0);
    check("redir_count", fetch_count, 3);
    check("redir_err", fetch_err, 0);
    step();
    check("redir_inst_pc", inst_pc, 32'h40);
    check("redir_data", rdata, 16);
    step();
    check("adv_pc", pc, 32'h44);
    check("adv_count", fetch_count, 4);
    redirect_valid = 1'b1; redirect_target = 32'h42;
    step();
    redirect_valid = 1'b0;
    check("mis_pc", pc, 32'h40);
    check("mis_err", fetch_err, 1);
    check("mis_irwrite", irwrite, 1);
    check("mis_valid", inst_valid, 0);
    step();
    check("mis_err_clr", fetch_err, 0);
    check("mis_inst_pc", inst_pc, 32'h40);
    check("mis_count", fetch_count, 4);
    redirect_valid = 1'b1; redirect_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_pc", pc, 32'h80);
      check("hold_irwrite", irwrite, 1);
      check("hold_valid", inst_valid, 0);
      check("hold_count", fetch_count, 4);
    end
    redirect_valid = 1'b0;
    step();
    check("hold_inst_pc", inst_pc, 32'h80);
    check("hold_rel_valid", inst_valid, 1);
    rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h13;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    check("mid_rst_count", fetch_count, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_inst_pc", inst_pc, 0);
    check("mid_rst_valid", inst_valid, 0);
    check("mid_rst_irwrite", irwrite, 0);
    check("mid_rst_err", fetch_err, 0);
    step();
    check("post_rst_irwrite", irwrite, 1);
    check("post_rst_pc", pc, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
